// File: rtl/inst_fetch.sv
// Instruction fetch: PC generation, one-cycle-latency ROM reads, and a small
// {addr, inst} buffer presented to decode over valid/ready, with redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } entry_t;

    entry_t          fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     pc;
    logic [31:0]     pend_pc;
    logic            pend;
    logic            drop;
    logic            pop;
    logic            push;
    logic [CW:0]     occ;

    assign inst_valid_o = (count != '0);
    assign pop          = inst_valid_o && inst_ready_i;
    assign push         = pend && !drop;

    // Occupancy once the in-flight return lands and this cycle's pop leaves;
    // issuing only below depth guarantees every return has a free slot.
    assign occ        = (CW+1)'(count) + (CW+1)'(pend) - (CW+1)'(pop);
    assign rom_ce_o   = !rst && !jump_en_i && (occ < (CW+1)'(FIFO_DEPTH));
    assign rom_addr_o = pc;

    assign inst_o      = inst_valid_o ? fifo_q[rd_ptr].inst : NOP_INST;
    assign inst_addr_o = inst_valid_o ? fifo_q[rd_ptr].addr : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_ADDR;
            pend    <= 1'b0;
            pend_pc <= RESET_ADDR;
            drop    <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (jump_en_i) begin
            // Redirect flushes everything, including a return landing now.
            pc     <= {jump_addr_i[31:2], 2'b00};
            pend   <= 1'b0;
            drop   <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rom_ce_o) begin
                pc      <= pc + 32'd4;
                pend    <= 1'b1;
                pend_pc <= pc;
            end else begin
                pend <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !jump_en_i && push) begin
            fifo_q[wr_ptr] <= '{addr: pend_pc, inst: rom_data_i};
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a ROM model returning word index as data, directed
// timing checks, and a scoreboard of the expected in-order accepted stream.
module tb_inst_fetch;

    localparam logic [31:0] RA  = 32'h0000_0000;
    localparam int          D   = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = 32'h0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    // Expected accepted addresses: after reset/redirect to T, decode must see
    // T, T+4, T+8, ... in order; the instruction is always the word index.
    logic [31:0] q[$];
    logic [31:0] nxt_addr;

    inst_fetch #(.RESET_ADDR(RA), .FIFO_DEPTH(D), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o)
    );

    always #5 clk = ~clk;

    // ROM: mem[i] = i; garbage on cycles with no request.
    always @(posedge clk) rom_data_i <= rom_ce_o ? (rom_addr_o >> 2) : $urandom;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic fill();
        while (q.size() < 64) begin
            q.push_back(nxt_addr);
            nxt_addr += 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        q.delete();
        nxt_addr = {a[31:2], 2'b00};
        fill();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        fill();
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic        p_hold = 1'b0;
    logic        p_rst  = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic [31:0] p_inst = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            chk("ce_in_reset", {31'b0, rom_ce_o}, 32'd0);
        end else begin
            if (p_rst) chk("valid_after_reset", {31'b0, inst_valid_o}, 32'd0);
            if (jump_en_i) chk("ce_in_jump", {31'b0, rom_ce_o}, 32'd0);
            chk("rom_align", {30'b0, rom_addr_o[1:0]}, 32'd0);
            if (!inst_valid_o) begin
                chk("empty_inst", inst_o, NOP);
                chk("empty_addr", inst_addr_o, 32'h0);
            end
            if (p_hold) begin
                chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
                chk("hold_addr", inst_addr_o, p_addr);
                chk("hold_inst", inst_o, p_inst);
            end
            if (inst_valid_o && inst_ready_i && !jump_en_i) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: accepted addr %h with nothing expected", inst_addr_o);
                end else begin
                    chk("accept_addr", inst_addr_o, q[0]);
                    chk("accept_inst", inst_o, q[0] >> 2);
                    q.delete(0);
                    accepts++;
                end
            end
        end
        p_hold <= !rst && inst_valid_o && !inst_ready_i && !jump_en_i;
        p_addr <= inst_addr_o;
        p_inst <= inst_o;
        p_rst  <= rst;
    end

    initial begin
        int r;
        restart(RA);
        nxt();
        nxt();
        #1;
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_addr", inst_addr_o, 32'h0);
        chk("rst_ce", {31'b0, rom_ce_o}, 32'd0);
        chk("rst_rom_addr", rom_addr_o, RA);

        // Startup latency and steady stream
        nxt(); rst = 1'b0; inst_ready_i = 1'b1; #1;
        chk("c0_ce", {31'b0, rom_ce_o}, 32'd1);
        chk("c0_addr", rom_addr_o, RA);
        nxt(); #1;
        chk("c1_valid", {31'b0, inst_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            chk("stream_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("stream_addr", inst_addr_o, RA + 32'(4 * k));
            chk("stream_inst", inst_o, (RA >> 2) + 32'(k));
        end

        // Backpressure from cycle 2 for 6 cycles
        nxt(); rst = 1'b1; restart(RA);
        nxt(); rst = 1'b0;
        nxt();
        nxt(); inst_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) nxt();
            #1;
            chk("bp_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("bp_addr", inst_addr_o, RA);
            chk("bp_ce", {31'b0, rom_ce_o}, 32'd0);
        end
        nxt(); inst_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) nxt();
            #1;
            chk("release_valid", {31'b0, inst_valid_o}, 32'd1);
            chk("release_addr", inst_addr_o, RA + 32'(4 * k));
        end

        // Redirect with a return in flight
        nxt(); #1;
        chk("pre_jump_ce", {31'b0, rom_ce_o}, 32'd1);
        nxt(); jump_en_i = 1'b1; jump_addr_i = 32'h103; restart(32'h103); #1;
        chk("jump_ce", {31'b0, rom_ce_o}, 32'd0);
        nxt(); jump_en_i = 1'b0; #1;
        chk("j1_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("j1_ce", {31'b0, rom_ce_o}, 32'd1);
        chk("j1_rom_addr", rom_addr_o, 32'h100);
        nxt(); #1;
        chk("j2_valid", {31'b0, inst_valid_o}, 32'd0);
        nxt(); #1;
        chk("j3_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("j3_addr", inst_addr_o, 32'h100);
        chk("j3_inst", inst_o, 32'h40);

        // Redirect and pop together with a full buffer
        for (int k = 0; k < 5; k++) begin nxt(); inst_ready_i = 1'b0; end
        #1;
        chk("full_ce", {31'b0, rom_ce_o}, 32'd0);
        nxt(); inst_ready_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h200; restart(32'h200);
        nxt(); jump_en_i = 1'b0; #1;
        chk("jp1_valid", {31'b0, inst_valid_o}, 32'd0);
        nxt(); #1;
        chk("jp2_valid", {31'b0, inst_valid_o}, 32'd0);
        nxt(); #1;
        chk("jp3_addr", inst_addr_o, 32'h200);
        chk("jp3_inst", inst_o, 32'h80);

        // Reset pulse while streaming
        repeat (3) nxt();
        nxt(); rst = 1'b1; restart(RA);
        nxt(); rst = 1'b0; #1;
        chk("rp_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rp_inst", inst_o, NOP);
        chk("rp_addr", inst_addr_o, 32'h0);
        chk("rp_ce", {31'b0, rom_ce_o}, 32'd1);
        chk("rp_rom_addr", rom_addr_o, RA);
        nxt();
        nxt(); #1;
        chk("rp_restart_addr", inst_addr_o, RA);

        // PC wrap
        nxt(); jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC; restart(32'hFFFF_FFFC);
        nxt(); jump_en_i = 1'b0;
        nxt();
        nxt(); #1;
        chk("wrap_addr_hi", inst_addr_o, 32'hFFFF_FFFC);
        chk("wrap_inst_hi", inst_o, 32'h3FFF_FFFF);
        nxt(); #1;
        chk("wrap_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("wrap_addr_lo", inst_addr_o, 32'h0);
        chk("wrap_inst_lo", inst_o, 32'h0);

        // Randomized traffic: ready, redirects (incl. back-to-back), resets
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst = 1'b0;
            jump_en_i = 1'b0;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                rst = 1'b1;
                restart(RA);
            end else if (r < 12) begin
                jump_en_i = 1'b1;
                jump_addr_i = (r < 3) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                restart(jump_addr_i);
            end
            inst_ready_i = ($urandom_range(0, 3) != 0);
        end
        nxt(); rst = 1'b0; jump_en_i = 1'b0; inst_ready_i = 1'b1;
        repeat (10) nxt();
        chk("accepts_seen", {31'b0, accepts > 1000}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
